// File: rtl/cordic_sincos_iter_pkg.sv
// Shared constants, FSM state type and real-to-fixed conversion for the
// iterative CORDIC sine/cosine core.
package cordic_pkg;

  localparam real K_REAL       = 0.6072529350;
  localparam real HALF_PI_REAL = 1.5707963268;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Round-to-nearest (ties away from zero) conversion to a fixed-point integer.
  function automatic longint to_fix(input real r, input int fracs);
    real scaled;
    scaled = r * (2.0 ** fracs);
    if (scaled >= 0.0) begin
      return longint'($rtoi(scaled + 0.5));
    end else begin
      return -longint'($rtoi(0.5 - scaled));
    end
  endfunction

endpackage

// File: rtl/cordic_sincos_iter_if.sv
// Angle-in / sine-cosine-out handshake bundle of the CORDIC core.
interface cordic_sincos_iter_if #(
  parameter int WIDTH = 23
);
  logic signed [WIDTH-1:0] theta;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;
  logic                    range_err;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  theta, in_valid, out_ready,
    output in_ready, cos_out, sin_out, range_err, out_valid
  );

  modport master (
    output theta, in_valid, out_ready,
    input  in_ready, cos_out, sin_out, range_err, out_valid
  );
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: atan_o = round(atan(2^-idx) * 2^FRACS).
// The table is padded to a power of two so any index value is legal.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int FRACS = 21,
  parameter int ITERS = 16,
  parameter int DW    = 25,
  parameter int CW    = 5
) (
  input  logic        [CW-1:0] idx_i,
  output logic signed [DW-1:0] atan_o
);

  logic signed [DW-1:0] rom_s [2**CW];

  for (genvar gi = 0; gi < 2**CW; gi++) begin : g_rom
    if (gi < ITERS) begin : g_used
      localparam longint ATAN_FIX = to_fix($atan(2.0 ** (-gi)), FRACS);
      assign rom_s[gi] = DW'(ATAN_FIX);
    end else begin : g_pad
      assign rom_s[gi] = '0;
    end
  end

  assign atan_o = rom_s[idx_i];

endmodule

// File: rtl/cordic_sincos_iter.sv
// Iterative CORDIC rotator: one micro-rotation per enabled clock, producing
// saturated cos/sin of a Q(INTS).(FRACS) angle with range checking.
module cordic_sincos_iter
  import cordic_pkg::*;
#(
  parameter int FRACS = 21,
  parameter int INTS  = 1,
  parameter int WIDTH = INTS + FRACS + 1,
  parameter int ITERS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  cordic_sincos_iter_if.slave  bus
);

  localparam int DW = WIDTH + 2;
  localparam int CW = $clog2(ITERS + 1);

  localparam logic signed [DW-1:0] K_FIX       = DW'(to_fix(K_REAL, FRACS));
  localparam logic signed [DW-1:0] HALF_PI_FIX = DW'(to_fix(HALF_PI_REAL, FRACS));
  localparam logic signed [DW-1:0] ONE_FIX     = {{(DW-1){1'b0}}, 1'b1} << FRACS;

  state_e                  state_q, state_d;
  logic        [CW-1:0]    cnt_q, cnt_d;
  logic signed [DW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic                    err_q, err_d;
  logic signed [WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;

  logic signed [DW-1:0]    atan_s, x_sh_s, y_sh_s, x_rot_s, y_rot_s, z_rot_s, theta_ext_s;
  logic                    out_of_range_s;

  function automatic logic signed [WIDTH-1:0] sat_trunc(input logic signed [DW-1:0] v);
    logic signed [DW-1:0] t;
    if (v > ONE_FIX) begin
      t = ONE_FIX;
    end else if (v < -ONE_FIX) begin
      t = -ONE_FIX;
    end else begin
      t = v;
    end
    return t[WIDTH-1:0];
  endfunction

  cordic_atan_rom #(
    .FRACS (FRACS),
    .ITERS (ITERS),
    .DW    (DW),
    .CW    (CW)
  ) u_atan_rom (
    .idx_i  (cnt_q),
    .atan_o (atan_s)
  );

  assign theta_ext_s    = {{(DW-WIDTH){bus.theta[WIDTH-1]}}, bus.theta};
  assign out_of_range_s = (theta_ext_s > HALF_PI_FIX) || (theta_ext_s < -HALF_PI_FIX);

  // Single micro-rotation; the sign of the residual angle picks the direction.
  assign x_sh_s  = x_q >>> cnt_q;
  assign y_sh_s  = y_q >>> cnt_q;
  assign x_rot_s = z_q[DW-1] ? (x_q + y_sh_s)  : (x_q - y_sh_s);
  assign y_rot_s = z_q[DW-1] ? (y_q - x_sh_s)  : (y_q + x_sh_s);
  assign z_rot_s = z_q[DW-1] ? (z_q + atan_s)  : (z_q - atan_s);

  // Next-state and datapath load decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    err_d   = err_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = ITER;
          cnt_d   = '0;
          x_d     = K_FIX;
          y_d     = '0;
          z_d     = theta_ext_s;
          err_d   = out_of_range_s;
        end else begin
          state_d = IDLE;
        end
      end
      ITER: begin
        x_d   = x_rot_s;
        y_d   = y_rot_s;
        z_d   = z_rot_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) begin
          state_d = DONE;
          cos_d   = err_q ? '0 : sat_trunc(x_rot_s);
          sin_d   = err_q ? '0 : sat_trunc(y_rot_s);
        end else begin
          state_d = ITER;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; a low clk_en freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      err_q   <= err_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.cos_out   = cos_q;
  assign bus.sin_out   = sin_q;
  assign bus.range_err = err_q;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Self-checking bench for cordic_sincos_iter: vector table, randomized angles
// against a CORDIC reference plus ideal trig, and handshake/enable/reset sequences.
module tb_cordic_sincos_iter;

  localparam int     FRACS = 21;
  localparam int     WIDTH = 23;
  localparam int     ITERS = 16;
  localparam longint ONE   = 2097152;
  localparam longint KFIX  = 1273502;
  localparam longint HPFIX = 3294199;
  localparam longint TOL   = 100;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
  int   checks   = 0;
  int   failures = 0;
  longint atan_t [ITERS];

  typedef struct {
    longint theta;
    longint exp_cos;
    longint exp_sin;
    logic   exp_err;
  } vec_t;
  vec_t vecs [8];

  cordic_sincos_iter_if #(.WIDTH(WIDTH)) bus ();

  cordic_sincos_iter #(
    .FRACS (FRACS),
    .INTS  (1),
    .WIDTH (WIDTH),
    .ITERS (ITERS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint rnd(input real v);
    if (v >= 0.0) return longint'($rtoi(v + 0.5));
    else return -longint'($rtoi(0.5 - v));
  endfunction

  function automatic longint labs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference rotator: the CORDIC recurrence in plain 64-bit arithmetic.
  function automatic void model(input longint th, output longint c, output longint s,
                                output logic e);
    longint x, y, z, xn, yn;
    x = KFIX; y = 0; z = th;
    e = (th > HPFIX) || (th < -HPFIX);
    for (int i = 0; i < ITERS; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i); yn = y + (x >>> i); z = z - atan_t[i];
      end else begin
        xn = x + (y >>> i); yn = y - (x >>> i); z = z + atan_t[i];
      end
      x = xn; y = yn;
    end
    c = (x > ONE) ? ONE : ((x < -ONE) ? -ONE : x);
    s = (y > ONE) ? ONE : ((y < -ONE) ? -ONE : y);
    if (e) begin c = 0; s = 0; end
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input longint act, input longint exp);
    checks++;
    if (labs(act - exp) > TOL) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, TOL);
    end
  endtask

  // Present theta, accept it, then count enabled+disabled edges until out_valid.
  task automatic start_and_wait(input longint th, input int drop_at, input int drop_len,
                                output int lat);
    int tmo;
    @(negedge clk);
    tmo = 0;
    while (bus.in_ready !== 1'b1 && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    chk("in_ready_before_accept", longint'(bus.in_ready), 1);
    bus.theta    = WIDTH'(th);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.theta    = WIDTH'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      if (lat == drop_at) clk_en = 1'b0;
      if (lat == drop_at + drop_len) clk_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    clk_en = 1'b1;
    if (lat >= 200) chk("out_valid_timeout", lat, -1);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_check(input longint th, input longint exp_c, input longint exp_s,
                           input logic exp_e, input int exp_lat, input int drop_at,
                           input int drop_len);
    int lat;
    longint mc, ms;
    logic me;
    model(th, mc, ms, me);
    start_and_wait(th, drop_at, drop_len, lat);
    chk("latency", lat, exp_lat);
    chk("range_err", longint'(bus.range_err), longint'(exp_e));
    chk("cos_ref", longint'(bus.cos_out), mc);
    chk("sin_ref", longint'(bus.sin_out), ms);
    chk_tol("cos_ideal", longint'(bus.cos_out), exp_c);
    chk_tol("sin_ideal", longint'(bus.sin_out), exp_s);
    chk("sin_within_one", longint'(labs(longint'(bus.sin_out)) <= ONE), 1);
    drain();
  endtask

  initial begin
    int     lat;
    longint th, c0, s0, mc, ms;
    logic   me;
    real    ang;

    for (int i = 0; i < ITERS; i++) atan_t[i] = rnd($atan(2.0 ** (-i)) * 2097152.0);

    vecs[0] = '{0,        2097152, 0,        1'b0};
    vecs[1] = '{1098066,  1816187, 1048576,  1'b0};
    vecs[2] = '{-1098066, 1816187, -1048576, 1'b0};
    vecs[3] = '{3294199,  0,       2097152,  1'b0};
    vecs[4] = '{-3294199, 0,       -2097152, 1'b0};
    vecs[5] = '{-4194304, 0,       0,        1'b1};
    vecs[6] = '{4194303,  0,       0,        1'b1};
    vecs[7] = '{3294200,  0,       0,        1'b1};

    reset = 1'b0; clk_en = 1'b1;
    bus.theta = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_cos", longint'(bus.cos_out), 0);
    chk("rst_sin", longint'(bus.sin_out), 0);
    chk("rst_err", longint'(bus.range_err), 0);
    reset = 1'b1;

    foreach (vecs[i])
      run_check(vecs[i].theta, vecs[i].exp_cos, vecs[i].exp_sin, vecs[i].exp_err, 16, -1, 0);

    for (int n = 0; n < 30; n++) begin
      th  = longint'(int'($urandom_range(0, 6800000))) - 3400000;
      ang = real'(th) / 2097152.0;
      if ((th > HPFIX) || (th < -HPFIX)) run_check(th, 0, 0, 1'b1, 16, -1, 0);
      else run_check(th, rnd($cos(ang) * 2097152.0), rnd($sin(ang) * 2097152.0), 1'b0, 16, -1, 0);
    end

    // Backpressure: results stay put for 10 cycles and an in_valid pulse is ignored.
    start_and_wait(1098066, -1, 0, lat);
    c0 = longint'(bus.cos_out);
    s0 = longint'(bus.sin_out);
    model(1098066, mc, ms, me);
    chk("bp_cos_ref", c0, mc);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i == 3);
      bus.theta    = '0;
      chk("bp_in_ready", longint'(bus.in_ready), 0);
      chk("bp_out_valid", longint'(bus.out_valid), 1);
      chk("bp_cos_stable", longint'(bus.cos_out), c0);
      chk("bp_sin_stable", longint'(bus.sin_out), s0);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    drain();
    chk("bp_release_in_ready", longint'(bus.in_ready), 1);
    repeat (3) @(negedge clk);
    chk("bp_pulse_ignored", longint'(bus.out_valid), 0);

    // No accept on the DONE->IDLE edge; the next edge accepts.
    start_and_wait(500000, -1, 0, lat);
    bus.theta = WIDTH'(-700000); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("xfer_no_same_cycle_accept", longint'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("xfer_accept_next", longint'(bus.in_ready), 0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("xfer_latency", lat, 16);
    model(-700000, mc, ms, me);
    chk("xfer_sin_ref", longint'(bus.sin_out), ms);
    drain();

    // Clock enable low for 5 cycles mid-rotation stretches latency by 5.
    ang = 1098066.0 / 2097152.0;
    run_check(1098066, rnd($cos(ang) * 2097152.0), rnd($sin(ang) * 2097152.0), 1'b0, 21, 5, 5);

    // Reset pulse at iteration 7 discards the operation and clears outputs at once.
    bus.theta = WIDTH'(2000000); bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid_busy", longint'(bus.in_ready), 0);
    chk("mid_prev_cos_held", longint'(bus.cos_out != 0), 1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_cos", longint'(bus.cos_out), 0);
    chk("mid_rst_sin", longint'(bus.sin_out), 0);
    chk("mid_rst_err", longint'(bus.range_err), 0);
    chk("mid_rst_out_valid", longint'(bus.out_valid), 0);
    chk("mid_rst_in_ready", longint'(bus.in_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    run_check(0, 2097152, 0, 1'b0, 16, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
